// File: rtl/protocolo_rtc.sv
// protocolo_rtc: bus engine for a multiplexed address/data RTC (CS/RD/WR/AoD).
// Optional feature macro: PROTOCOLO_RTC_FREEZE_EN (camb_* flags freeze data_vga).
module protocolo_rtc #(
    parameter int T_PHASE = 8,
    parameter int T_GAP   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       IndicadorMaquina,
    input  logic [7:0] address,
    input  logic [7:0] DATA_WRITE,
    input  logic       camb_hora,
    input  logic       camb_fecha,
    input  logic       camb_crono,
    output logic       ChipSelect,
    output logic       Write,
    output logic       Read,
    output logic       AoD,
    inout  wire  [7:0] DATA_ADDRESS,
    output logic       bit_inicio,
    output logic [7:0] data_vga
);

    localparam int CMAX = (T_GAP > T_PHASE) ? T_GAP : T_PHASE;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] C_GAP  = CW'(T_GAP);
    localparam logic [CW-1:0] C_PEND = CW'(T_PHASE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_REL,
        S_DATA,
        S_DATA_REL
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    logic          r_dir;
    logic [7:0]    r_addr;
    logic [7:0]    r_wdata;

    logic          r_cs;
    logic          r_wr;
    logic          r_rd;
    logic          r_aod;
    logic          r_bit;
    logic          r_oe;
    logic [7:0]    r_bus;
    logic [7:0]    r_vga;

    logic          w_cs;
    logic          w_wr;
    logic          w_rd;
    logic          w_aod;
    logic          w_oe;
    logic [7:0]    w_bus;
    logic          w_start;
    logic          w_capture;
    logic          w_freeze;

`ifdef PROTOCOLO_RTC_FREEZE_EN
    assign w_freeze = camb_hora | camb_fecha | camb_crono;
`else
    logic w_unused_camb;
    assign w_unused_camb = camb_hora ^ camb_fecha ^ camb_crono;
    assign w_freeze = 1'b0;
`endif

    // Next state and phase counter; gap counter re-enters IDLE at 1 so the
    // bit_inicio cycle is the last of T_GAP idle cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        unique case (r_state)
            S_IDLE: begin
                if (r_cnt == C_GAP) begin
                    w_state_nxt = S_ADDR;
                    w_cnt_nxt   = '0;
                end
            end
            S_ADDR: begin
                if (r_cnt == C_PEND) begin
                    w_state_nxt = S_ADDR_REL;
                    w_cnt_nxt   = '0;
                end
            end
            S_ADDR_REL: begin
                if (r_cnt == C_PEND) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                end
            end
            S_DATA: begin
                if (r_cnt == C_PEND) begin
                    w_state_nxt = S_DATA_REL;
                    w_cnt_nxt   = '0;
                end
            end
            S_DATA_REL: begin
                if (r_cnt == C_PEND) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the next state so every pin comes straight off a flop.
    always_comb begin
        w_cs    = 1'b1;
        w_wr    = 1'b1;
        w_rd    = 1'b1;
        w_aod   = 1'b1;
        w_oe    = 1'b0;
        w_bus   = r_wdata;
        w_start = (w_state_nxt == S_IDLE) && (w_cnt_nxt == C_GAP);
        unique case (w_state_nxt)
            S_ADDR: begin
                w_cs  = 1'b0;
                w_wr  = 1'b0;
                w_aod = 1'b0;
                w_oe  = 1'b1;
                w_bus = r_addr;
            end
            S_ADDR_REL: begin
                w_aod = 1'b0;
                w_oe  = 1'b1;
                w_bus = r_addr;
            end
            S_DATA: begin
                w_cs = 1'b0;
                w_wr = ~r_dir;
                w_rd = r_dir;
                w_oe = r_dir;
            end
            S_DATA_REL: begin
                w_oe = r_dir;
            end
            default: begin
            end
        endcase
    end

    assign w_capture = (r_state == S_DATA) && (w_state_nxt == S_DATA_REL) && !r_dir;

    // State and phase counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Transaction parameters latched once at the start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_start) begin
            r_dir   <= IndicadorMaquina;
            r_addr  <= address;
            r_wdata <= DATA_WRITE;
        end
    end

    // Registered bus control and drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs  <= 1'b1;
            r_wr  <= 1'b1;
            r_rd  <= 1'b1;
            r_aod <= 1'b1;
            r_bit <= 1'b0;
            r_oe  <= 1'b0;
            r_bus <= '0;
        end else begin
            r_cs  <= w_cs;
            r_wr  <= w_wr;
            r_rd  <= w_rd;
            r_aod <= w_aod;
            r_bit <= w_start;
            r_oe  <= w_oe;
            r_bus <= w_bus;
        end
    end

    // Read byte captured at the end of DATA, visible on DATA_REL entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vga <= '0;
        end else if (w_capture && !w_freeze) begin
            r_vga <= DATA_ADDRESS;
        end
    end

    assign ChipSelect   = r_cs;
    assign Write        = r_wr;
    assign Read         = r_rd;
    assign AoD          = r_aod;
    assign bit_inicio   = r_bit;
    assign data_vga     = r_vga;
    assign DATA_ADDRESS = r_oe ? r_bus : 8'hzz;

endmodule

// File: tb/tb_protocolo_rtc.sv
// tb_protocolo_rtc: scoreboard bench for protocolo_rtc with a simple RTC model.
// Expectations follow PROTOCOLO_RTC_FREEZE_EN when it is defined.
module tb_protocolo_rtc;

    localparam int TP = 8;
    localparam int TG = 16;
    localparam int N  = 9;

    typedef struct {
        logic       dir;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] r;
        logic [2:0] camb;
        logic [7:0] vb;
        logic [7:0] va;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       im = 1'b1;
    logic [7:0] addr = 8'h00;
    logic [7:0] wd = 8'h00;
    logic       ch = 1'b0;
    logic       cf = 1'b0;
    logic       cc = 1'b0;
    logic       cs;
    logic       wr;
    logic       rd;
    logic       aod;
    logic       bi;
    logic [7:0] vga;
    wire  [7:0] bus;

    logic       probe_en = 1'b0;
    logic [7:0] rtc_val = 8'h00;
    logic [7:0] model_vga = 8'h00;
    logic [12:0] s_vec;
    logic [7:0] s_vga;

    int n_cmp = 0;
    int n_bad = 0;

    txn_t sb_q[$];

    logic       t_dir [N] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] t_a [N] = '{8'h0A, 8'h0A, 8'h21, 8'h22, 8'h22, 8'h41, 8'h43, 8'h44, 8'h0B};
    logic [7:0] t_d [N] = '{8'h0F, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h96};
    logic [7:0] t_r [N] = '{8'h00, 8'h00, 8'h59, 8'h23, 8'h23, 8'h00, 8'hA7, 8'h5E, 8'h00};
    logic [2:0] t_c [N] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b010, 3'b001, 3'b000};

    string ph_name [4] = '{"addr", "addr_rel", "data", "data_rel"};

    // RTC drives the bus while selected for read; probe stands in for a pull-down.
    assign bus = probe_en ? 8'h00 : ((!cs && !rd) ? rtc_val : 8'hzz);

    protocolo_rtc #(
        .T_PHASE(TP),
        .T_GAP  (TG)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .IndicadorMaquina(im),
        .address         (addr),
        .DATA_WRITE      (wd),
        .camb_hora       (ch),
        .camb_fecha      (cf),
        .camb_crono      (cc),
        .ChipSelect      (cs),
        .Write           (wr),
        .Read            (rd),
        .AoD             (aod),
        .DATA_ADDRESS    (bus),
        .bit_inicio      (bi),
        .data_vga        (vga)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic smp(input logic pr);
        @(negedge clk);
        probe_en = pr;
        #1;
        s_vec = {bi, cs, wr, rd, aod, bus};
        s_vga = vga;
        probe_en = 1'b0;
    endtask

    task automatic push(input int i);
        txn_t e;
        logic frz;
        frz = 1'b0;
`ifdef PROTOCOLO_RTC_FREEZE_EN
        frz = (t_c[i] != 3'b000);
`endif
        e.dir  = t_dir[i];
        e.a    = t_a[i];
        e.d    = t_d[i];
        e.r    = t_r[i];
        e.camb = t_c[i];
        e.vb   = model_vga;
        if (!e.dir && !frz) model_vga = e.r;
        e.va   = model_vga;
        im   = e.dir;
        addr = e.a;
        wd   = e.dir ? e.d : 8'($urandom);
        sb_q.push_back(e);
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            smp(1'b1);
            n++;
            chk("idle", 32'(s_vec[11:0]), {20'h0, 4'hF, 8'h00});
        end while (!s_vec[12] && n < 100);
        chk("start_seen", 32'(s_vec[12]), 32'd1);
    endtask

    task automatic run_txn(input int i);
        txn_t e;
        logic [3:0] xc;
        logic [7:0] xb;
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        rtc_val = e.r;
        {ch, cf, cc} = e.camb;
        if (i + 1 < N) push(i + 1);
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < TP; c++) begin
                smp((p == 3) && !e.dir);
                case (p)
                    0: begin
                        xc = 4'b0010;
                        xb = e.a;
                    end
                    1: begin
                        xc = 4'b1110;
                        xb = e.a;
                    end
                    2: begin
                        xc = e.dir ? 4'b0011 : 4'b0101;
                        xb = e.dir ? e.d : e.r;
                    end
                    default: begin
                        xc = 4'b1111;
                        xb = e.dir ? e.d : 8'h00;
                    end
                endcase
                chk($sformatf("t%0d_%s", i, ph_name[p]), 32'(s_vec), 32'({1'b0, xc, xb}));
                if (p == 2 && c == TP - 1)
                    chk($sformatf("t%0d_vga_hold", i), 32'(s_vga), 32'(e.vb));
                if (p == 3 && c == 0)
                    chk($sformatf("t%0d_vga_upd", i), 32'(s_vga), 32'(e.va));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        txn_t e;
        repeat (3) @(negedge clk);
        probe_en = 1'b1;
        #1;
        chk("rst_ctl", 32'({bi, cs, wr, rd, aod}), 32'b01111);
        chk("rst_bus", 32'(bus), 32'h00);
        chk("rst_vga", 32'(vga), 32'h00);
        probe_en = 1'b0;

        push(0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_start(n);
        chk("first_start", 32'(n), 32'(TG));

        for (int i = 0; i < N - 1; i++) begin
            run_txn(i);
            wait_start(n);
            chk($sformatf("t%0d_gap", i), 32'(n), 32'(TG));
        end

        if (sb_q.size() == 0) begin
            chk("sb_last", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            rtc_val = e.r;
            {ch, cf, cc} = e.camb;
            for (int c = 0; c < 2 * TP + 3; c++) smp(1'b0);
            chk("rst_pre", 32'(s_vec), 32'({1'b0, 4'b0011, e.d}));
            rst_n = 1'b0;
            #1;
            probe_en = 1'b1;
            #1;
            chk("rst_mid_ctl", 32'({bi, cs, wr, rd, aod}), 32'b01111);
            chk("rst_mid_bus", 32'(bus), 32'h00);
            chk("rst_mid_vga", 32'(vga), 32'h00);
            probe_en = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            wait_start(n);
            chk("rst_restart", 32'(n), 32'(TG));
        end

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
